// File: rtl/rs_pkg.sv
// Shared types for the reservation station: entry layout, widths and tag helpers.
// Tags are stored at RS_TAG_W bits internally; ROBsizeLog must not exceed RS_TAG_W.
package rs_pkg;
   localparam int RS_CMD_W = 10;
   localparam int RS_VAL_W = 64;
   localparam int RS_TAG_W = 8;

   typedef logic [RS_TAG_W-1:0] rs_tag_t;

   typedef struct packed {
      logic                valid;
      rs_tag_t             dest;
      rs_tag_t             tag1;
      rs_tag_t             tag2;
      logic [RS_VAL_W-1:0] val1;
      logic [RS_VAL_W-1:0] val2;
      logic [RS_CMD_W-1:0] cmd;
   } rs_entry_t;

   function automatic logic tag_ready(input rs_tag_t tag);
      return tag == '0;
   endfunction
endpackage

// File: rtl/reservation_station_if.sv
// Decode/CDB/issue bundle of the reservation station; master is the pipeline side,
// slave is the station.
interface reservation_station_if #(parameter int TAG_W = 6);
   logic                         writeEn_i;
   logic [TAG_W-1:0]             ROBTag_i;
   logic [TAG_W-1:0]             ROBTag1_i;
   logic [TAG_W-1:0]             ROBTag2_i;
   logic [rs_pkg::RS_VAL_W-1:0]  ROBval1_i;
   logic [rs_pkg::RS_VAL_W-1:0]  ROBval2_i;
   logic [rs_pkg::RS_CMD_W-1:0]  commands_i;
   logic                         stall_o;
   logic                         cdbValid_i;
   logic [TAG_W-1:0]             cdbTag_i;
   logic [rs_pkg::RS_VAL_W-1:0]  cdbData_i;
   logic                         flush_i;
   logic                         issueValid_o;
   logic                         issueReady_i;
   logic [TAG_W-1:0]             issueTag_o;
   logic [rs_pkg::RS_VAL_W-1:0]  issueVal1_o;
   logic [rs_pkg::RS_VAL_W-1:0]  issueVal2_o;
   logic [rs_pkg::RS_CMD_W-1:0]  issueCommands_o;

   modport master (
      output writeEn_i, ROBTag_i, ROBTag1_i, ROBTag2_i, ROBval1_i, ROBval2_i, commands_i,
      output cdbValid_i, cdbTag_i, cdbData_i, flush_i, issueReady_i,
      input  stall_o, issueValid_o, issueTag_o, issueVal1_o, issueVal2_o, issueCommands_o
   );

   modport slave (
      input  writeEn_i, ROBTag_i, ROBTag1_i, ROBTag2_i, ROBval1_i, ROBval2_i, commands_i,
      input  cdbValid_i, cdbTag_i, cdbData_i, flush_i, issueReady_i,
      output stall_o, issueValid_o, issueTag_o, issueVal1_o, issueVal2_o, issueCommands_o
   );
endinterface

// File: rtl/rs_select.sv
// Issue picker: one-hot grant of the ready entry with the smallest age rank, ties to lowest index.
// Purely combinational; with all-zero ages it degenerates to a lowest-index priority pick.
module rs_select #(
   parameter int N     = 4,
   parameter int AGE_W = 2
) (
   input  logic [N-1:0]       ready,
   input  logic [N*AGE_W-1:0] age,
   output logic [N-1:0]       grant,
   output logic               any_ready
);
   logic [AGE_W-1:0] best;

   always_comb begin
      grant     = '0;
      any_ready = 1'b0;
      best      = '0;
      for (int i = 0; i < N; i++) begin
         // strict compare keeps the earlier index on equal ranks
         if (ready[i] && (!any_ready || (age[i*AGE_W +: AGE_W] < best))) begin
            grant     = '0;
            grant[i]  = 1'b1;
            best      = age[i*AGE_W +: AGE_W];
            any_ready = 1'b1;
         end
      end
   end
endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: entries wait on CDB tags, issue one ready entry per cycle
// (visible the cycle after write/wake-up); stall_o = all full; issue held while issueReady_i=0.
// RS_OLDEST_FIRST_EN selects oldest-ready issue instead of lowest-index.
module reservation_station
   import rs_pkg::*;
#(
   parameter int ROBsize    = 32,
   parameter int ROBsizeLog = $clog2(ROBsize + 1),
   parameter int RSdepth    = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   reservation_station_if.slave  rs
);
   localparam int AGE_W = (RSdepth > 1) ? $clog2(RSdepth) : 1;

   rs_entry_t                ent_q [RSdepth];
   rs_entry_t                ent_d [RSdepth];
   rs_entry_t                new_ent;
   rs_entry_t                iss;
   logic [RSdepth-1:0]       ready;
   logic [RSdepth-1:0]       sel_grant;
   logic [RSdepth-1:0]       grant;
   logic [RSdepth-1:0]       free_oh;
   logic [RSdepth*AGE_W-1:0] age_flat;
   logic                     any_ready;
   logic                     found;
   logic                     write_ok;
   logic                     fire;
   logic                     hold_vld_q;
   logic [RSdepth-1:0]       hold_grant_q;
   rs_tag_t                  cdb_tag;

   assign cdb_tag  = RS_TAG_W'(rs.cdbTag_i);
   assign rs.stall_o = &free_oh == 1'b0 && found == 1'b0;
   assign write_ok = rs.writeEn_i & found;
   assign fire     = any_ready & rs.issueReady_i;

   always_comb begin
      free_oh = '0;
      found   = 1'b0;
      for (int i = 0; i < RSdepth; i++) begin
         ready[i] = ent_q[i].valid & tag_ready(ent_q[i].tag1) & tag_ready(ent_q[i].tag2);
         if (!ent_q[i].valid && !found) begin
            free_oh[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   rs_select #(.N(RSdepth), .AGE_W(AGE_W)) u_select (
      .ready     (ready),
      .age       (age_flat),
      .grant     (sel_grant),
      .any_ready (any_ready)
   );

   // a stalled issue keeps its pick so a later wake-up cannot swap the presented entry
   assign grant = hold_vld_q ? hold_grant_q : sel_grant;

   always_comb begin
      iss = '0;
      for (int i = 0; i < RSdepth; i++) begin
         if (grant[i]) iss = ent_q[i];
      end
   end

   assign rs.issueValid_o    = any_ready;
   assign rs.issueTag_o      = any_ready ? ROBsizeLog'(iss.dest) : '0;
   assign rs.issueVal1_o     = any_ready ? iss.val1 : '0;
   assign rs.issueVal2_o     = any_ready ? iss.val2 : '0;
   assign rs.issueCommands_o = any_ready ? iss.cmd  : '0;

   always_comb begin
      new_ent       = '0;
      new_ent.valid = 1'b1;
      new_ent.dest  = RS_TAG_W'(rs.ROBTag_i);
      new_ent.tag1  = RS_TAG_W'(rs.ROBTag1_i);
      new_ent.tag2  = RS_TAG_W'(rs.ROBTag2_i);
      new_ent.val1  = rs.ROBval1_i;
      new_ent.val2  = rs.ROBval2_i;
      new_ent.cmd   = rs.commands_i;
      if (rs.cdbValid_i && !tag_ready(new_ent.tag1) && new_ent.tag1 == cdb_tag) begin
         new_ent.tag1 = '0;
         new_ent.val1 = rs.cdbData_i;
      end
      if (rs.cdbValid_i && !tag_ready(new_ent.tag2) && new_ent.tag2 == cdb_tag) begin
         new_ent.tag2 = '0;
         new_ent.val2 = rs.cdbData_i;
      end
   end

   always_comb begin
      for (int i = 0; i < RSdepth; i++) begin
         ent_d[i] = ent_q[i];
         if (fire && grant[i]) ent_d[i].valid = 1'b0;
         if (ent_q[i].valid && rs.cdbValid_i) begin
            if (!tag_ready(ent_q[i].tag1) && ent_q[i].tag1 == cdb_tag) begin
               ent_d[i].tag1 = '0;
               ent_d[i].val1 = rs.cdbData_i;
            end
            if (!tag_ready(ent_q[i].tag2) && ent_q[i].tag2 == cdb_tag) begin
               ent_d[i].tag2 = '0;
               ent_d[i].val2 = rs.cdbData_i;
            end
         end
         if (write_ok && free_oh[i]) ent_d[i] = new_ent;
         if (rs.flush_i) ent_d[i].valid = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < RSdepth; i++) ent_q[i] <= '0;
         hold_vld_q   <= 1'b0;
         hold_grant_q <= '0;
      end else begin
         for (int i = 0; i < RSdepth; i++) ent_q[i] <= ent_d[i];
         hold_vld_q   <= any_ready & ~rs.issueReady_i & ~rs.flush_i;
         hold_grant_q <= grant;
      end
   end

`ifdef RS_OLDEST_FIRST_EN
   // rank = number of older valid entries; ranks stay dense 0..n-1 across issue and write
   logic [AGE_W-1:0] age_q [RSdepth];
   logic [AGE_W-1:0] age_d [RSdepth];
   logic [AGE_W-1:0] iss_rank;
   logic [AGE_W:0]   cnt;

   always_comb begin
      cnt      = '0;
      iss_rank = '0;
      for (int i = 0; i < RSdepth; i++) begin
         cnt = cnt + (AGE_W+1)'(ent_q[i].valid);
         if (grant[i]) iss_rank = age_q[i];
      end
      for (int i = 0; i < RSdepth; i++) begin
         age_d[i] = age_q[i];
         age_flat[i*AGE_W +: AGE_W] = age_q[i];
         if (fire && ent_q[i].valid && !grant[i] && age_q[i] > iss_rank)
            age_d[i] = age_q[i] - 1'b1;
         if (write_ok && free_oh[i])
            age_d[i] = AGE_W'(cnt - (AGE_W+1)'(fire));
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < RSdepth; i++) age_q[i] <= '0;
      end else begin
         for (int i = 0; i < RSdepth; i++) age_q[i] <= age_d[i];
      end
   end
`else
   assign age_flat = '0;
`endif
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: vector table for single-entry flows, then
// hand sequences for full/stall, held issue, flush, mid-run reset and issue ordering.
module tb_reservation_station;
   localparam int TW = 6;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   reservation_station_if #(.TAG_W(TW)) bus ();

   reservation_station #(.ROBsize(32), .ROBsizeLog(TW), .RSdepth(4)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .rs      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          rst, we, tag, t1, t2;
      logic [63:0] v1, v2;
      int          cmd, cv, ct;
      logic [63:0] cd;
      int          fl, rdy;
      int          e_stall, e_iv, e_tag;
      logic [63:0] e_v1, e_v2;
      int          e_cmd;
   } vec_t;

   vec_t vt [18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic es, input logic eiv, input logic [5:0] etag,
                          input logic [63:0] ev1, input logic [63:0] ev2, input logic [9:0] ecmd);
      chk({nm, ".stall"}, 64'(bus.stall_o), 64'(es));
      chk({nm, ".valid"}, 64'(bus.issueValid_o), 64'(eiv));
      chk({nm, ".tag"},   64'(bus.issueTag_o), 64'(etag));
      chk({nm, ".val1"},  bus.issueVal1_o, ev1);
      chk({nm, ".val2"},  bus.issueVal2_o, ev2);
      chk({nm, ".cmd"},   64'(bus.issueCommands_o), 64'(ecmd));
   endtask

   task automatic idle();
      rst              = 1'b0;
      bus.writeEn_i    = 1'b0;
      bus.ROBTag_i     = '0;
      bus.ROBTag1_i    = '0;
      bus.ROBTag2_i    = '0;
      bus.ROBval1_i    = '0;
      bus.ROBval2_i    = '0;
      bus.commands_i   = '0;
      bus.cdbValid_i   = 1'b0;
      bus.cdbTag_i     = '0;
      bus.cdbData_i    = '0;
      bus.flush_i      = 1'b0;
      bus.issueReady_i = 1'b0;
   endtask

   task automatic wr(input logic [5:0] dest, input logic [5:0] t1, input logic [5:0] t2,
                     input logic [63:0] v1, input logic [63:0] v2, input logic [9:0] cmd);
      bus.writeEn_i  = 1'b1;
      bus.ROBTag_i   = dest;
      bus.ROBTag1_i  = t1;
      bus.ROBTag2_i  = t2;
      bus.ROBval1_i  = v1;
      bus.ROBval2_i  = v2;
      bus.commands_i = cmd;
   endtask

   task automatic cdb(input logic [5:0] t, input logic [63:0] d);
      bus.cdbValid_i = 1'b1;
      bus.cdbTag_i   = t;
      bus.cdbData_i  = d;
   endtask

   task automatic apply(input vec_t v);
      rst              = v.rst[0];
      bus.writeEn_i    = v.we[0];
      bus.ROBTag_i     = 6'(v.tag);
      bus.ROBTag1_i    = 6'(v.t1);
      bus.ROBTag2_i    = 6'(v.t2);
      bus.ROBval1_i    = v.v1;
      bus.ROBval2_i    = v.v2;
      bus.commands_i   = 10'(v.cmd);
      bus.cdbValid_i   = v.cv[0];
      bus.cdbTag_i     = 6'(v.ct);
      bus.cdbData_i    = v.cd;
      bus.flush_i      = v.fl[0];
      bus.issueReady_i = v.rdy[0];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  first_tag, second_tag;
      logic [63:0] first_v2, second_v2;

      // {rst,we,tag,t1,t2,v1,v2,cmd,cv,ct,cd,fl,rdy, e_stall,e_iv,e_tag,e_v1,e_v2,e_cmd}
      vt[0]  = '{1,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,0,    0,0,0,64'h0,64'h0,0};
      vt[1]  = '{0,1,5,0,0,64'h3,64'h4,'h11,0,0,64'h0,0,0, 0,0,0,64'h0,64'h0,0};
      vt[2]  = '{0,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,1,    0,1,5,64'h3,64'h4,'h11};
      vt[3]  = '{0,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,0,    0,0,0,64'h0,64'h0,0};
      vt[4]  = '{0,1,6,7,0,64'h0,64'h22,'h22,0,0,64'h0,0,0, 0,0,0,64'h0,64'h0,0};
      vt[5]  = '{0,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,1,    0,0,0,64'h0,64'h0,0};
      vt[6]  = '{0,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,0,    0,0,0,64'h0,64'h0,0};
      vt[7]  = '{0,0,0,0,0,64'h0,64'h0,0,1,7,64'hAB,0,1,   0,0,0,64'h0,64'h0,0};
      vt[8]  = '{0,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,1,    0,1,6,64'hAB,64'h22,'h22};
      vt[9]  = '{0,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,0,    0,0,0,64'h0,64'h0,0};
      vt[10] = '{0,1,8,0,9,64'h5,64'h0,'h33,1,9,64'hCD,0,0, 0,0,0,64'h0,64'h0,0};
      vt[11] = '{0,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,1,    0,1,8,64'h5,64'hCD,'h33};
      vt[12] = '{0,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,0,    0,0,0,64'h0,64'h0,0};
      vt[13] = '{0,1,10,12,0,64'h0,64'h1,'h44,0,12,64'hEE,0,0, 0,0,0,64'h0,64'h0,0};
      vt[14] = '{0,0,0,0,0,64'h0,64'h0,0,1,13,64'hEE,0,1,  0,0,0,64'h0,64'h0,0};
      vt[15] = '{0,0,0,0,0,64'h0,64'h0,0,1,12,64'h77,0,0,  0,0,0,64'h0,64'h0,0};
      vt[16] = '{0,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,1,    0,1,10,64'h77,64'h1,'h44};
      vt[17] = '{0,0,0,0,0,64'h0,64'h0,0,0,0,64'h0,0,0,    0,0,0,64'h0,64'h0,0};

      idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         apply(vt[i]);
         #1;
         chk_out($sformatf("vec%0d", i), vt[i].e_stall[0], vt[i].e_iv[0], 6'(vt[i].e_tag),
                 vt[i].e_v1, vt[i].e_v2, 10'(vt[i].e_cmd));
      end

      // fill all four slots with waiting entries, fifth write must be dropped
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); idle();
         wr(6'(20 + i), 6'(30 + i), 6'd0, 64'h0, 64'(64'h100 + i), 10'(i));
         #1; chk_out($sformatf("fill%0d", i), 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);
      end
      @(negedge clk); idle(); wr(6'd24, 6'd0, 6'd0, 64'h55, 64'h0, 10'd0);
      #1; chk_out("full_write", 1'b1, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);
      @(negedge clk); idle(); cdb(6'd31, 64'h99);
      #1; chk_out("full_dropped", 1'b1, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);
      @(negedge clk); idle(); bus.issueReady_i = 1'b1;
      #1; chk_out("full_issue", 1'b1, 1'b1, 6'd21, 64'h99, 64'h101, 10'd1);
      @(negedge clk); idle();
      #1; chk_out("full_freed", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);

      // held issue: a lower-index entry wakes mid-stall and must not displace it
      wr(6'd25, 6'd0, 6'd0, 64'h1234, 64'h5678, 10'h3FF);
      #1; chk_out("hold_wr", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); idle();
         if (k == 1) cdb(6'd30, 64'h42);
         #1; chk_out($sformatf("hold%0d", k), 1'b1, 1'b1, 6'd25, 64'h1234, 64'h5678, 10'h3FF);
      end
      @(negedge clk); idle(); bus.flush_i = 1'b1; bus.issueReady_i = 1'b1;
      #1; chk_out("flush_cyc", 1'b1, 1'b1, 6'd25, 64'h1234, 64'h5678, 10'h3FF);
      @(negedge clk); idle();
      #1; chk_out("flush_after", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);

      // write coinciding with flush is discarded
      @(negedge clk); idle(); wr(6'd26, 6'd0, 6'd0, 64'h1, 64'h2, 10'd3); bus.flush_i = 1'b1;
      #1; chk_out("flush_wr", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);
      @(negedge clk); idle();
      #1; chk_out("flush_wr_gone", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);

      // reset mid-operation wins over write and issue
      wr(6'd27, 6'd0, 6'd0, 64'h7, 64'h8, 10'd9);
      #1; chk_out("rst_pre", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);
      @(negedge clk); idle(); rst = 1'b1; wr(6'd28, 6'd0, 6'd0, 64'h1, 64'h1, 10'd1);
      bus.issueReady_i = 1'b1;
      #1; chk_out("rst_cyc", 1'b0, 1'b1, 6'd27, 64'h7, 64'h8, 10'd9);
      @(negedge clk); idle();
      #1; chk_out("rst_after", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);

      // ordering: A lands in slot 1, younger B in slot 0, both woken together
      wr(6'd2, 6'd0, 6'd0, 64'h2, 64'h0, 10'd2);
      #1; chk_out("ord_x", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);
      @(negedge clk); idle(); wr(6'd3, 6'd50, 6'd0, 64'h0, 64'h3, 10'd3); bus.issueReady_i = 1'b1;
      #1; chk_out("ord_a", 1'b0, 1'b1, 6'd2, 64'h2, 64'h0, 10'd2);
      @(negedge clk); idle(); wr(6'd4, 6'd50, 6'd0, 64'h0, 64'h4, 10'd4);
      #1; chk_out("ord_b", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);
      @(negedge clk); idle(); cdb(6'd50, 64'h5A);
      #1; chk_out("ord_wake", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);
`ifdef RS_OLDEST_FIRST_EN
      first_tag = 6'd3; first_v2 = 64'h3; second_tag = 6'd4; second_v2 = 64'h4;
`else
      first_tag = 6'd4; first_v2 = 64'h4; second_tag = 6'd3; second_v2 = 64'h3;
`endif
      @(negedge clk); idle(); bus.issueReady_i = 1'b1;
      #1; chk_out("ord_first", 1'b0, 1'b1, first_tag, 64'h5A, first_v2, 10'(first_tag));
      @(negedge clk); idle(); bus.issueReady_i = 1'b1;
      #1; chk_out("ord_second", 1'b0, 1'b1, second_tag, 64'h5A, second_v2, 10'(second_tag));
      @(negedge clk); idle();
      #1; chk_out("ord_empty", 1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 10'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
